multicore_system_mem_loader: RTL and testbench
==============================================

Name: multicore_system_mem_loader

Overview:
Avalon-MM initiator that loads a program image into one core's dual-port on-chip memory via the memory's second port (s2). It accepts a 32-bit word stream (valid/ready), writes words to consecutive word addresses, and optionally reads the region back to verify a 32-bit checksum. While loading, it holds the target core in reset through core_reset_req. One instance sits beside each core_N memory in the multicore system.

Parameters:
ADDR_W, 12, memory word-address width (4096 words)
DATA_W, 32, memory data width; byteenable width is DATA_W/8
CNT_W, 13, word_count width (allows 0..4096)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  single-cycle request; sampled only in IDLE
base_addr  in  ADDR_W  first word address, latched on start
word_count  in  CNT_W  number of words, latched on start
s_valid  in  1  stream word valid
s_data  in  DATA_W  stream word
s_ready  out  1  stream word accepted when s_valid&s_ready
mem_address  out  ADDR_W  to memory address2
mem_byteenable  out  DATA_W/8  to byteenable2; constant all-ones
mem_chipselect  out  1  to chipselect2
mem_write  out  1  to write2
mem_writedata  out  DATA_W  to writedata2
mem_clken  out  1  to clken2; 1 whenever not in reset
mem_readdata  in  DATA_W  from readdata2
core_reset_req  out  1  hold target core in reset
busy  out  1  high in any state other than IDLE/DONE
done  out  1  level, set on completion, cleared on next accepted start
error  out  1  level, checksum mismatch, cleared on next accepted start

Behaviour:
- Reset values: all outputs 0 except mem_byteenable = all-ones; state IDLE. mem_clken rises the first cycle after reset deasserts.
- States: IDLE -> WRITE -> (VERIFY -> VERIFY_DRAIN) -> DONE -> IDLE.
- IDLE: on start, latch base_addr/word_count, clear done/error and sum_wr/sum_rd, set core_reset_req. If word_count==0, go to DONE (no memory access); otherwise go to WRITE. start is ignored outside IDLE and DONE. DONE behaves as IDLE for start.
- WRITE: s_ready=1. Each cycle with s_valid: chipselect=write=1 combinationally with data=s_data and address=ptr; ptr increments modulo 2^ADDR_W (wrap 4095->0 is legal). sum_wr += s_data mod 2^32; remaining decrements. The last accepted word goes to VERIFY (feature on) or DONE. When s_valid=0, chipselect=write=0 (stall; no bubble write).
- VERIFY: reset ptr to base. Issue one read per cycle (chipselect=1, write=0) for word_count cycles. The memory registers the address and leaves the output unregistered, so readdata is valid exactly 1 cycle after the address is issued. A 1-bit rd_pending pipeline accumulates sum_rd. After the final issue, go to VERIFY_DRAIN.
- VERIFY_DRAIN: 1 cycle; accumulate the last readdata; error = (sum_rd != sum_wr); go to DONE.
- DONE: done=1, core_reset_req=0, busy=0.
- Reset mid-operation: immediately abort. chipselect/write drop asynchronously, core_reset_req=0, and the partial image is left in memory.
- Simultaneous start and completion is impossible, because start is only sampled in IDLE/DONE.

Optional Feature:
MEM_LOADER_VERIFY_EN. When defined: the VERIFY/VERIFY_DRAIN readback and checksum are present, and error is driven as above. When undefined: WRITE goes directly to DONE, no reads are issued, sum logic is removed, and error is tied 0.

Decomposition:
- Package multicore_system_mem_loader_pkg: state enum (IDLE, WRITE, VERIFY, VERIFY_DRAIN, DONE), ADDR_W/DATA_W/CNT_W defaults, BE_ALL_ONES constant.
- Sub-module multicore_system_mem_loader_csum: 32-bit clearable accumulator with enable; instantiated twice (write sum, read sum) under MEM_LOADER_VERIFY_EN.

Test Plan:
- base=0x010, count=4, words 0x11111111..0x44444444 back-to-back -> writes at 0x010..0x013, 4 reads, error=0, done=1 at cycle 4+4+1+1 after start; core_reset_req high throughout.
- count=0 -> done=1 the next cycle, mem_chipselect never asserted, error=0.
- base=0xFFE, count=4 -> write addresses 0xFFE, 0xFFF, 0x000, 0x001; readback follows the same wrap.
- s_valid toggling 1,0,1,0 with count=3 -> write only on valid cycles, no writes during gaps, sum and done correct.
- Memory model corrupts word at 0x012 on readback (XOR 0x1) -> error=1, done=1.
- Assert reset during WRITE after 2 of 8 words -> all outputs return to reset values asynchronously; a later start with count=1 completes normally.

Source files
------------

// File: rtl/multicore_system_mem_loader_pkg.sv
// Shared types and defaults for the per-core program-image loader.
package multicore_system_mem_loader_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 13;

    localparam logic [DATA_W_DEF/8-1:0] BE_ALL_ONES = '1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        VERIFY,
        VERIFY_DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/multicore_system_mem_loader_if.sv
// Word stream plus the memory s2-port bus; master is the loader side.
interface multicore_system_mem_loader_if
    import multicore_system_mem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic                s_valid;
    logic [DATA_W-1:0]   s_data;
    logic                s_ready;

    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;

    modport master (
        input  s_valid, s_data, mem_readdata,
        output s_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );

    modport slave (
        output s_valid, s_data, mem_readdata,
        input  s_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );

endinterface

// File: rtl/multicore_system_mem_loader_csum.sv
// Clearable modulo-2^DATA_W accumulator; used only when MEM_LOADER_VERIFY_EN is defined.
// sum already includes the current cycle's din when en is high.
module multicore_system_mem_loader_csum
    import multicore_system_mem_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] acc_p1;

    function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    assign sum = en ? add_wrap(acc_p1, din) : acc_p1;

    // accumulator stage: cleared on a new load, data path carries no reset
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_p1 <= '0;
        end else if (en) begin
            acc_p1 <= sum;
        end
    end

endmodule

// File: rtl/multicore_system_mem_loader.sv
// Streams a program image into a core's dual-port memory via port s2, holding the core in reset.
// Readback checksum verification is built only when MEM_LOADER_VERIFY_EN is defined.
module multicore_system_mem_loader
    import multicore_system_mem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [CNT_W-1:0]              word_count,
    multicore_system_mem_loader_if.master mif,
    output logic                          core_reset_req,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr_p0;
    logic [CNT_W-1:0]  remain_p0;
    logic              start_acc;
    logic              wr_fire;
    logic              last_wr;
    logic              rd_fire;
    logic              done_q;
    logic              core_rst_q;
    logic              clken_q;

    assign start_acc = start && ((state == IDLE) || (state == DONE));
    assign wr_fire   = (state == WRITE) && mif.s_valid;
    assign last_wr   = wr_fire && (remain_p0 == CNT_W'(1));

`ifdef MEM_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] base_p0;
    logic [CNT_W-1:0]  count_p0;
    logic              last_rd;
    logic              rd_vld_p1;
    logic              err_q;
    logic [DATA_W-1:0] sum_wr;
    logic [DATA_W-1:0] sum_rd;

    assign rd_fire = (state == VERIFY);
    assign last_rd = rd_fire && (remain_p0 == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (start_acc) begin
            base_p0  <= base_addr;
            count_p0 <= word_count;
        end
    end

    // readback stage: memory returns data one cycle after the address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_p1 <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_fire;
            if (start_acc) begin
                err_q <= 1'b0;
            end else if (state == VERIFY_DRAIN) begin
                err_q <= (sum_rd != sum_wr);
            end
        end
    end

    multicore_system_mem_loader_csum #(.DATA_W(DATA_W)) u_sum_wr (
        .clk (clk),
        .clr (start_acc),
        .en  (wr_fire),
        .din (mif.s_data),
        .sum (sum_wr)
    );

    multicore_system_mem_loader_csum #(.DATA_W(DATA_W)) u_sum_rd (
        .clk (clk),
        .clr (start_acc),
        .en  (rd_vld_p1),
        .din (mif.mem_readdata),
        .sum (sum_rd)
    );

    assign error = err_q;
`else
    assign rd_fire = 1'b0;
    assign error   = 1'b0;
`endif

    always_comb begin
        state_nxt          = state;
        mif.s_ready        = 1'b0;
        mif.mem_chipselect = 1'b0;
        mif.mem_write      = 1'b0;
        mif.mem_writedata  = '0;
        case (state)
            IDLE, DONE: begin
                if (start_acc) begin
                    state_nxt = (word_count == '0) ? DONE : WRITE;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                mif.s_ready = 1'b1;
                if (mif.s_valid) begin
                    mif.mem_chipselect = 1'b1;
                    mif.mem_write      = 1'b1;
                    mif.mem_writedata  = mif.s_data;
                end
                if (last_wr) begin
`ifdef MEM_LOADER_VERIFY_EN
                    state_nxt = VERIFY;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef MEM_LOADER_VERIFY_EN
            VERIFY: begin
                mif.mem_chipselect = 1'b1;
                if (last_rd) begin
                    state_nxt = VERIFY_DRAIN;
                end
            end
            VERIFY_DRAIN: begin
                state_nxt = DONE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // control stage: everything that must abort immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            core_rst_q <= 1'b0;
            clken_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            clken_q <= 1'b1;
            if (start_acc) begin
                done_q     <= (word_count == '0);
                core_rst_q <= (word_count != '0);
            end else if (state_nxt == DONE) begin
                done_q     <= 1'b1;
                core_rst_q <= 1'b0;
            end
        end
    end

    // address stage: pointer rewinds to base for the readback pass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_p0    <= '0;
            remain_p0 <= '0;
        end else if (start_acc) begin
            ptr_p0    <= base_addr;
            remain_p0 <= word_count;
        end else if (wr_fire) begin
`ifdef MEM_LOADER_VERIFY_EN
            if (last_wr) begin
                ptr_p0    <= base_p0;
                remain_p0 <= count_p0;
            end else begin
                ptr_p0    <= ptr_p0 + ADDR_W'(1);
                remain_p0 <= remain_p0 - CNT_W'(1);
            end
`else
            ptr_p0    <= ptr_p0 + ADDR_W'(1);
            remain_p0 <= remain_p0 - CNT_W'(1);
`endif
        end else if (rd_fire) begin
            ptr_p0    <= ptr_p0 + ADDR_W'(1);
            remain_p0 <= remain_p0 - CNT_W'(1);
        end
    end

    assign mif.mem_address    = ptr_p0;
    assign mif.mem_byteenable = '1;
    assign mif.mem_clken      = clken_q;
    assign core_reset_req     = core_rst_q;
    assign busy               = (state != IDLE) && (state != DONE);
    assign done               = done_q;

endmodule

// File: tb/tb_multicore_system_mem_loader.sv
// Randomized self-checking bench for the memory loader with a behavioural memory and reference model.
module tb_multicore_system_mem_loader;
    import multicore_system_mem_loader_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int CW = 13;
`ifdef MEM_LOADER_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic          core_reset_req, busy, done, error;

    multicore_system_mem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

    multicore_system_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .mif            (mif.master),
        .core_reset_req (core_reset_req),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    // Memory model: registered address, unregistered read output
    logic [DW-1:0] mem [0:4095];
    logic [AW-1:0] rd_addr_q = '0;
    int            corrupt_addr = -1;

    always @(posedge clk) begin
        if (mif.mem_clken && mif.mem_chipselect) begin
            if (mif.mem_write) mem[mif.mem_address] <= mif.mem_writedata;
            else               rd_addr_q <= mif.mem_address;
        end
    end

    assign mif.mem_readdata = mem[rd_addr_q] ^ ((int'(rd_addr_q) == corrupt_addr) ? 32'h1 : 32'h0);

    // Bus monitor
    logic [AW-1:0] wr_a_q[$];
    logic [DW-1:0] wr_d_q[$];
    logic [AW-1:0] rd_a_q[$];
    int            crr_viol = 0;

    always @(negedge clk) begin
        if (mif.mem_chipselect) begin
            if (mif.mem_write) begin
                wr_a_q.push_back(mif.mem_address);
                wr_d_q.push_back(mif.mem_writedata);
            end else begin
                rd_a_q.push_back(mif.mem_address);
            end
        end
        if (busy && !core_reset_req) crr_viol++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // vmode: 0 back-to-back, 1 alternate valid/idle, 2 random gaps
    task automatic run_load(input string tag, input logic [AW-1:0] base, input int cnt,
                            input int vmode, input int corrupt, input bit fixed, input bit chk_lat);
        logic [DW-1:0] w[$];
        logic [DW-1:0] sum_ok, sum_bad;
        int wr0, rd0, v0, cycles, idx, exp_lat, exp_rd, n;
        bit got_done, vld, acc, exp_err;
        logic [AW-1:0] a;

        for (int i = 0; i < cnt; i++) w.push_back(fixed ? 32'h11111111 * (i + 1) : $urandom);
        corrupt_addr = corrupt;
        wr0 = wr_a_q.size();
        rd0 = rd_a_q.size();
        v0  = crr_viol;

        start = 1'b1; base_addr = base; word_count = CW'(cnt); mif.s_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1; idx = 0;
        got_done = done;
        if (cnt > 0) begin
            check_eq({tag, "/core_reset_req_on"}, core_reset_req, 1);
            check_eq({tag, "/busy_on"}, busy, 1);
        end
        while (!got_done && cycles < 200 + 4 * cnt) begin
            vld = (idx < cnt) && ((vmode == 0) || (vmode == 1 && (cycles % 2) == 1) ||
                                  (vmode == 2 && $urandom_range(0, 2) != 0));
            mif.s_valid = vld;
            mif.s_data  = vld ? w[idx] : $urandom;
            acc = vld && mif.s_ready;
            @(posedge clk); #1;
            cycles++;
            if (acc) idx++;
            if (done) got_done = 1'b1;
        end
        mif.s_valid = 1'b0;

        // Reference: every word lands at base+i mod 4096; readback sum differs only if corrupted word is in range
        exp_err = 1'b0;
        sum_ok = '0; sum_bad = '0;
        for (int i = 0; i < cnt; i++) begin
            sum_ok += w[i];
            sum_bad += w[i] ^ ((((int'(base) + i) % 4096) == corrupt) ? 32'h1 : 32'h0);
        end
        exp_err = VERIFY_EN && (sum_ok != sum_bad);
        exp_lat = (cnt == 0) ? 1 : (VERIFY_EN ? 2 * cnt + 2 : cnt + 1);
        exp_rd  = VERIFY_EN ? cnt : 0;

        check_eq({tag, "/done"}, got_done, 1);
        if (chk_lat) check_eq({tag, "/latency"}, cycles, exp_lat);
        check_eq({tag, "/error"}, error, exp_err);
        check_eq({tag, "/busy_off"}, busy, 0);
        check_eq({tag, "/core_reset_req_off"}, core_reset_req, 0);
        check_eq({tag, "/core_reset_held"}, crr_viol - v0, 0);
        check_eq({tag, "/n_writes"}, wr_a_q.size() - wr0, cnt);
        n = (wr_a_q.size() - wr0 < cnt) ? wr_a_q.size() - wr0 : cnt;
        for (int i = 0; i < n; i++) begin
            a = AW'((int'(base) + i) % 4096);
            check_eq({tag, "/wr_addr"}, wr_a_q[wr0 + i], a);
            check_eq({tag, "/wr_data"}, wr_d_q[wr0 + i], w[i]);
        end
        check_eq({tag, "/n_reads"}, rd_a_q.size() - rd0, exp_rd);
        n = (rd_a_q.size() - rd0 < exp_rd) ? rd_a_q.size() - rd0 : exp_rd;
        for (int i = 0; i < n; i++) begin
            a = AW'((int'(base) + i) % 4096);
            check_eq({tag, "/rd_addr"}, rd_a_q[rd0 + i], a);
        end
    endtask

    task automatic run_abort();
        logic [DW-1:0] w0, w1;
        logic [AW-1:0] base, a;
        int wr0, idx, guard;
        bit acc;

        base = AW'($urandom_range(0, 4095));
        w0 = $urandom; w1 = $urandom;
        corrupt_addr = -1;
        wr0 = wr_a_q.size();
        start = 1'b1; base_addr = base; word_count = CW'(8);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; guard = 0;
        while (idx < 2 && guard < 20) begin
            mif.s_valid = 1'b1;
            mif.s_data  = (idx == 0) ? w0 : w1;
            acc = mif.s_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        mif.s_valid = 1'b1;
        mif.s_data  = $urandom;
        reset = 1'b1;
        #1;
        check_eq("abort/chipselect", mif.mem_chipselect, 0);
        check_eq("abort/write", mif.mem_write, 0);
        check_eq("abort/writedata", mif.mem_writedata, 0);
        check_eq("abort/address", mif.mem_address, 0);
        check_eq("abort/clken", mif.mem_clken, 0);
        check_eq("abort/s_ready", mif.s_ready, 0);
        check_eq("abort/core_reset_req", core_reset_req, 0);
        check_eq("abort/busy", busy, 0);
        check_eq("abort/done", done, 0);
        check_eq("abort/error", error, 0);
        check_eq("abort/byteenable", mif.mem_byteenable, BE_ALL_ONES);
        mif.s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort/n_writes", wr_a_q.size() - wr0, 2);
        check_eq("abort/mem0", mem[base], w0);
        a = base + AW'(1);
        check_eq("abort/mem1", mem[a], w1);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("abort/clken_back", mif.mem_clken, 1);
        check_eq("abort/idle_busy", busy, 0);
        run_load("after_abort", AW'($urandom_range(0, 4095)), 1, 0, -1, 1'b0, 1'b1);
    endtask

    initial begin
        int cnt, cor;
        logic [AW-1:0] b;

        mif.s_valid = 1'b0;
        mif.s_data  = '0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst/done", done, 0);
        check_eq("rst/error", error, 0);
        check_eq("rst/busy", busy, 0);
        check_eq("rst/core_reset_req", core_reset_req, 0);
        check_eq("rst/chipselect", mif.mem_chipselect, 0);
        check_eq("rst/write", mif.mem_write, 0);
        check_eq("rst/address", mif.mem_address, 0);
        check_eq("rst/s_ready", mif.s_ready, 0);
        check_eq("rst/clken", mif.mem_clken, 0);
        check_eq("rst/byteenable", mif.mem_byteenable, BE_ALL_ONES);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("rst/clken_rise", mif.mem_clken, 1);

        run_load("basic", 12'h010, 4, 0, -1, 1'b1, 1'b1);
        run_load("zero", 12'h123, 0, 0, -1, 1'b0, 1'b1);
        run_load("wrap", 12'hFFE, 4, 0, -1, 1'b0, 1'b1);
        run_load("toggle", 12'h200, 3, 1, -1, 1'b0, 1'b0);
        run_load("corrupt", 12'h010, 4, 0, 12'h012, 1'b0, 1'b1);
        run_abort();

        for (int t = 0; t < 8; t++) begin
            b   = AW'($urandom_range(0, 4095));
            cnt = $urandom_range(1, 16);
            cor = ($urandom_range(0, 1) != 0) ? ((int'(b) + $urandom_range(0, cnt - 1)) % 4096) : -1;
            run_load("rand", b, cnt, 2, cor, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
